tff_count_ctrl: RTL and testbench

- Sequencing controller for a WIDTH-bit bank of toggle flip-flops used as a programmable counter.
- Accepts commands over a valid/ready interface: LOAD, START_UP, START_DOWN, STOP.
- Computes the per-bit toggle-enable vector each cycle, runs the bank until a programmed target is reached, then signals completion.
- Sits between a host/sequencer and any logic needing timed counts (dividers, delay generators).

---
 rtl/tff_count_ctrl_if.sv | 13 +
 rtl/tff_count_ctrl.sv | 105 ++++++++++
 tb/tb_tff_count_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/tff_count_ctrl_if.sv
// Command channel for the toggle-flop counter controller: a valid/ready handshake
// that carries an opcode and a data word (load value or target).
interface tff_count_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;

    modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/tff_count_ctrl.sv
// Sequencer for a bank of toggle flops used as a programmable up/down counter.
// The bank is only ever written as count ^ t_vec, including for LOAD.
module tff_count_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    tff_count_ctrl_if.slave     cmd,
    input  logic                en,
    output logic [WIDTH-1:0]    t_vec,
    output logic [WIDTH-1:0]    count,
    output logic                busy,
    output logic                done,
    output logic                done_flag
);
    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_UP    = 2'b01;
    localparam logic [1:0] OP_DOWN  = 2'b10;
    localparam logic [1:0] OP_STOP  = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] target_q, target_d;
    logic             dir_q, dir_d;          // 0 = up, 1 = down
    logic             done_q, done_d;
    logic             flag_q, flag_d;
    logic [WIDTH-1:0] tvec_c;
    logic             ready_c;
    logic             accept_c;

    // Bit i toggles when every lower bit of c is 1 (ripple carry/borrow chain).
    function automatic logic [WIDTH-1:0] toggle_chain(input logic [WIDTH-1:0] c);
        logic [WIDTH-1:0] t;
        logic             run;
        run = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            t[i] = run;
            run  = run & c[i];
        end
        return t;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            target_q <= '0;
            dir_q    <= 1'b0;
            done_q   <= 1'b0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_q ^ tvec_c;
            target_q <= target_d;
            dir_q    <= dir_d;
            done_q   <= done_d;
            flag_q   <= flag_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        dir_d    = dir_q;
        done_d   = 1'b0;
        flag_d   = flag_q;
        tvec_c   = '0;
        // While running only STOP may pass; everything else stalls.
        ready_c  = (state_q != S_RUN) || (cmd.cmd_op == OP_STOP);
        accept_c = cmd.cmd_valid && ready_c;

        if (accept_c) begin
            flag_d = 1'b0;
            case (cmd.cmd_op)
                OP_LOAD: begin
                    tvec_c  = count_q ^ cmd.cmd_data;
                    state_d = S_IDLE;
                end
                OP_UP, OP_DOWN: begin
                    target_d = cmd.cmd_data;
                    dir_d    = (cmd.cmd_op == OP_DOWN);
                    state_d  = S_RUN;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q == S_RUN) begin
            if (count_q == target_q) begin
                state_d = S_DONE;
                done_d  = 1'b1;
                flag_d  = 1'b1;
            end else if (en) begin
                tvec_c = dir_q ? toggle_chain(~count_q) : toggle_chain(count_q);
            end
        end
    end

    assign cmd.cmd_ready = ready_c;
    assign t_vec         = tvec_c;
    assign count         = count_q;
    assign busy          = (state_q == S_RUN);
    assign done          = done_q;
    assign done_flag     = flag_q;
endmodule

// File: tb/tb_tff_count_ctrl.sv
// Directed bench for tff_count_ctrl with hand-computed expected values.
module tb_tff_count_ctrl;
    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         en;
    logic [W-1:0] t_vec;
    logic [W-1:0] count;
    logic         busy;
    logic         done;
    logic         done_flag;

    int errors = 0;
    int checks = 0;

    tff_count_ctrl_if #(.WIDTH(W)) cif ();

    tff_count_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (cif),
        .en        (en),
        .t_vec     (t_vec),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .done_flag (done_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [1:0] op, input logic [W-1:0] data);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op;
        cif.cmd_data  = data;
    endtask

    task automatic idle();
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = 2'b00;
        cif.cmd_data  = '0;
    endtask

    initial begin
        rst = 1'b0;
        en  = 1'b0;
        idle();
        #3;
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_flag", done_flag, 0);
        chk("rst_tvec", t_vec, 0);
        chk("rst_ready", cif.cmd_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        cyc();

        // LOAD 0x3C then count up to 0x40
        cmd(2'b00, 8'h3C); #1;
        chk("load_tvec", t_vec, 8'h3C);
        cyc();
        chk("load_count", count, 8'h3C);
        cmd(2'b01, 8'h40); en = 1'b1; #1;
        chk("start_tvec0", t_vec, 0);
        cyc(); idle(); #1;
        chk("up_busy", busy, 1);
        chk("up_tvec_3c", t_vec, 8'h01);
        cyc(); chk("up_3d", count, 8'h3D);
        cyc(); chk("up_3e", count, 8'h3E);
        cyc(); chk("up_3f", count, 8'h3F);
        chk("up_tvec_3f", t_vec, 8'h7F);
        cyc(); chk("up_40", count, 8'h40);
        chk("up_40_done", done, 0);
        chk("up_40_tvec", t_vec, 0);
        cyc();
        chk("up_done", done, 1);
        chk("up_done_busy", busy, 0);
        chk("up_done_flag", done_flag, 1);
        cyc();
        chk("up_done_pulse", done, 0);
        chk("up_flag_sticky", done_flag, 1);
        chk("up_hold", count, 8'h40);

        // Wrap upward through 0xFF
        cmd(2'b00, 8'hFE); cyc();
        chk("wrap_load", count, 8'hFE);
        chk("wrap_flag_clr", done_flag, 0);
        cmd(2'b01, 8'h01); cyc(); idle(); #1;
        chk("wrap_tvec_fe", t_vec, 8'h01);
        cyc(); chk("wrap_ff", count, 8'hFF);
        chk("wrap_tvec_ff", t_vec, 8'hFF);
        cyc(); chk("wrap_00", count, 8'h00);
        cyc(); chk("wrap_01", count, 8'h01);
        cyc(); chk("wrap_done", done, 1);

        // Down count with pauses
        cmd(2'b00, 8'h01); cyc();
        cmd(2'b10, 8'hFE); cyc(); idle(); #1;
        chk("dn_busy", busy, 1);
        cyc(); chk("dn_00", count, 8'h00);
        en = 1'b0; #1;
        chk("dn_pause_tvec", t_vec, 0);
        cyc(); chk("dn_hold1", count, 8'h00);
        cyc(); chk("dn_hold2", count, 8'h00);
        chk("dn_hold_busy", busy, 1);
        en = 1'b1; #1;
        chk("dn_tvec_00", t_vec, 8'hFF);
        cyc(); chk("dn_ff", count, 8'hFF);
        cyc(); chk("dn_fe", count, 8'hFE);
        chk("dn_fe_done", done, 0);
        cyc(); chk("dn_done", done, 1);
        cyc(); chk("dn_done_pulse", done, 0);

        // Stall non-STOP commands in RUN, then STOP
        cmd(2'b00, 8'h00); cyc();
        cmd(2'b01, 8'h10); cyc();
        cmd(2'b00, 8'hAA); #1;
        chk("stall_ready", cif.cmd_ready, 0);
        for (int i = 0; i < 7; i++) begin
            cif.cmd_data = 8'h55 + 8'(i);
            cyc();
        end
        chk("stall_count", count, 8'h07);
        chk("stall_busy", busy, 1);
        cif.cmd_op = 2'b11; #1;
        chk("stop_ready", cif.cmd_ready, 1);
        cyc(); idle(); #1;
        chk("stop_busy", busy, 0);
        chk("stop_count", count, 8'h07);
        cyc();
        chk("stop_hold", count, 8'h07);
        chk("stop_done", done, 0);
        chk("stop_flag", done_flag, 0);

        // STOP on the cycle count reaches target
        cmd(2'b00, 8'h09); cyc();
        cmd(2'b01, 8'h0A); cyc(); idle();
        cyc(); chk("race_0a", count, 8'h0A);
        cmd(2'b11, 8'h00); cyc(); idle(); #1;
        chk("race_done", done, 0);
        chk("race_flag", done_flag, 0);
        chk("race_busy", busy, 0);
        cyc();
        chk("race_done2", done, 0);
        chk("race_count", count, 8'h0A);

        // Same without STOP
        cmd(2'b00, 8'h09); cyc();
        cmd(2'b01, 8'h0A); cyc(); idle();
        cyc(); chk("norace_0a", count, 8'h0A);
        cyc(); chk("norace_done", done, 1);
        chk("norace_flag", done_flag, 1);
        cyc(); chk("norace_pulse", done, 0);
        cyc(); chk("norace_sticky", done_flag, 1);
        cmd(2'b00, 8'h55); cyc(); idle(); #1;
        chk("norace_load_clr", done_flag, 0);
        chk("norace_load", count, 8'h55);

        // Asynchronous reset mid-RUN
        cmd(2'b00, 8'h00); cyc();
        cmd(2'b01, 8'h20); cyc(); idle();
        for (int i = 0; i < 5; i++) cyc();
        chk("arst_pre", count, 8'h05);
        #3 rst = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_busy", busy, 0);
        chk("arst_flag", done_flag, 0);
        chk("arst_ready", cif.cmd_ready, 1);
        #1 rst = 1'b1;
        cmd(2'b00, 8'h12); cyc(); idle(); #1;
        chk("arst_load", count, 8'h12);
        chk("arst_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
